// File: rtl/pipeline_pkg.sv
// Definitions shared by the execution register, the memory stage and the register file.
package pipeline_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 4;
  localparam int CNT_W      = 4;

  typedef enum logic [0:0] {
    ST_IDLE      = 1'b0,
    ST_LOAD_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/data_ram.sv
// Word-addressed data RAM: synchronous write, combinational read.
module data_ram
  import pipeline_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  // NOTE: the array has no reset; clearing it would force a flop-based
  // implementation instead of a RAM macro.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: stores complete in one cycle, loads stall upstream for
// READ_LATENCY cycles before producing the registered writeback bundle.
module memory_stage
  import pipeline_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_W-1:0]     data_val_in,
  input  logic [DATA_W-1:0]     result_in,
  input  logic [REG_ADDR_W-1:0] c_addr_in,
  input  logic                  reg_write_in,
  input  logic                  data_read_in,
  input  logic                  data_write_in,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic                  wb_en,
  output logic                  stall
);

  localparam logic [CNT_W-1:0] LP_LATENCY = CNT_W'(READ_LATENCY);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [ADDR_W-1:0]       r_ld_addr;
  logic [REG_ADDR_W-1:0]   r_ld_reg;
  logic                    r_ld_we;

  logic [ADDR_W-1:0]       w_addr;
  logic                    w_ram_we;
  logic [DATA_W-1:0]       w_rdata;

  assign w_addr   = result_in[ADDR_W-1:0];
  // A simultaneous read and write request is a load; the store half is dropped.
  assign w_ram_we = (r_state == ST_IDLE) && data_write_in && !data_read_in;

  data_ram #(.ADDR_W(ADDR_W)) u_data_ram (
    .i_clk   (CLK),
    .i_we    (w_ram_we),
    .i_waddr (w_addr),
    .i_wdata (data_val_in),
    .i_raddr (r_ld_addr),
    .o_rdata (w_rdata)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_ld_addr <= '0;
      r_ld_reg  <= '0;
      r_ld_we   <= 1'b0;
      wb_data   <= '0;
      wb_addr   <= '0;
      wb_en     <= 1'b0;
      stall     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (data_read_in) begin
            r_ld_addr <= w_addr;
            r_ld_reg  <= c_addr_in;
            r_ld_we   <= reg_write_in;
            r_cnt     <= LP_LATENCY;
            stall     <= 1'b1;
            wb_en     <= 1'b0;
            r_state   <= ST_LOAD_WAIT;
          end else begin
            wb_en   <= reg_write_in;
            wb_data <= result_in;
            wb_addr <= c_addr_in;
          end
        end
        ST_LOAD_WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          // Counter reaches zero on this edge: retire the load.
          if (r_cnt == CNT_W'(1)) begin
            wb_data <= w_rdata;
            wb_addr <= r_ld_reg;
            wb_en   <= r_ld_we;
            stall   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
